crc_seq_ctrl: RTL

Job sequencer for the byte-serial CRC-32 engine. It accepts a job (seed, byte length, output inversion) and a 32-bit word stream over a valid/ready handshake. It drives the engine's ACT/CMD/BE/DI write port to load the seed, then feeds one byte per clock. It reads back the final CRC and returns it with a one-cycle DONE pulse. It sits between a DMA/packet client and the CRC engine, and is the only master of the engine's port.

---
 rtl/crc_seq_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/crc_seq_ctrl.sv
// Job sequencer for the byte-serial CRC-32 engine: loads the seed, streams
// job bytes one per clock into the engine, and returns the final CRC.
module crc_seq_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_START,
    input  logic             i_ABORT,
    input  logic [31:0]      i_SEED,
    input  logic [LEN_W-1:0] i_LEN,
    input  logic             i_XOROUT,
    output logic             o_BUSY,
    input  logic             i_WVALID,
    input  logic [31:0]      i_WDATA,
    output logic             o_WREADY,
    output logic             o_DONE,
    output logic [31:0]      o_RESULT,
    output logic             o_CACT,
    output logic             o_CCMD,
    output logic [4:0]       o_CBE,
    output logic [39:0]      o_CDI,
    input  logic [39:0]      i_CDO
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_FETCH, S_FEED, S_DRAIN, S_CAPTURE
    } state_t;

    state_t           r_state;
    logic [31:0]      r_seed;
    logic [LEN_W-1:0] r_rem;
    logic             r_xor;
    logic [31:0]      r_buf;
    logic [1:0]       r_idx;
    logic [2:0]       r_k;
    logic             r_done;
    logic [31:0]      r_result;

    logic [2:0]       w_k;
    logic [7:0]       w_byte;
    logic             w_abort;
    logic             w_unused_cdo;

    // Bytes taken from the next word: at most four, never more than remain.
    assign w_k          = (r_rem >= LEN_W'(4)) ? 3'd4 : r_rem[2:0];
    assign w_byte       = r_buf[{r_idx, 3'b000} +: 8];
    assign w_abort      = i_ABORT && (r_state != S_IDLE);
    assign w_unused_cdo = ^i_CDO[39:32];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= S_IDLE;
            r_seed   <= '0;
            r_rem    <= '0;
            r_xor    <= 1'b0;
            r_buf    <= '0;
            r_idx    <= '0;
            r_k      <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_START) begin
                            r_seed  <= i_SEED;
                            r_rem   <= i_LEN;
                            r_xor   <= i_XOROUT;
                            r_state <= S_SEED;
                        end
                    end
                    S_SEED: begin
                        r_state <= (r_rem == '0) ? S_DRAIN : S_FETCH;
                    end
                    S_FETCH: begin
                        if (i_WVALID) begin
                            r_buf   <= i_WDATA;
                            r_idx   <= '0;
                            r_k     <= w_k;
                            r_state <= S_FEED;
                        end
                    end
                    S_FEED: begin
                        r_idx <= r_idx + 2'd1;
                        r_rem <= r_rem - LEN_W'(1);
                        if ({1'b0, r_idx} == (r_k - 3'd1)) begin
                            r_state <= (r_rem != LEN_W'(1)) ? S_FETCH : S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        r_state <= S_CAPTURE;
                    end
                    S_CAPTURE: begin
                        r_result <= i_CDO[31:0] ^ {32{r_xor}};
                        r_done   <= 1'b1;
                        r_state  <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Engine port and WREADY decode straight from state; ABORT blanks them at once.
    always_comb begin
        o_CACT   = 1'b0;
        o_CCMD   = 1'b0;
        o_CBE    = 5'b11111;
        o_CDI    = '0;
        o_WREADY = 1'b0;
        if (!w_abort) begin
            case (r_state)
                S_SEED: begin
                    o_CACT = 1'b1;
                    o_CBE  = 5'b10000;
                    o_CDI  = {8'h00, r_seed};
                end
                S_FETCH: begin
                    o_WREADY = 1'b1;
                end
                S_FEED: begin
                    o_CACT = 1'b1;
                    o_CBE  = 5'b01111;
                    o_CDI  = {w_byte, 32'h0000_0000};
                end
                default: ;
            endcase
        end
    end

    assign o_BUSY   = (r_state != S_IDLE);
    assign o_DONE   = r_done;
    assign o_RESULT = r_result;

endmodule
